// File: rtl/frac_clk_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
//   ch_w()        : width of the channel-select field for a given channel count
//   cfg_t         : one channel's ratio/phase configuration
//   chan_state_t  : one channel's complete registered state
//   cfg_ok()      : ratio/phase legality check applied when a request is accepted
// Ratio fields are carried at ACC_MAX_W bits. Channels truncate their results
// back to their own ACC_W, so the upper bits stay constant zero in hardware.
package frac_clk_pkg;

  localparam int ACC_MAX_W  = 32;  // widest supported ACC_W
  localparam int LOCK_CNT_W = 8;   // supports LOCK_EDGES up to 255

  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic [ACC_MAX_W-1:0] mul;
    logic [ACC_MAX_W-1:0] div;
    logic [ACC_MAX_W-1:0] phase;
  } cfg_t;

  typedef struct packed {
    logic [ACC_MAX_W-1:0]  acc;
    logic [ACC_MAX_W-1:0]  mul;
    logic [ACC_MAX_W-1:0]  div;
    logic [ACC_MAX_W-1:0]  phase;
    logic                  ce;
    logic                  clk_q;
    logic [LOCK_CNT_W-1:0] lock_cnt;
    logic                  locked;
  } chan_state_t;

  // A ratio must satisfy 0 < mul <= div, and the preload must be below div.
  function automatic logic cfg_ok(input cfg_t c);
    return (c.div != '0) && (c.mul != '0) && (c.mul <= c.div) && (c.phase < c.div);
  endfunction

endpackage

// File: rtl/frac_ce_channel.sv
// One fractional enable channel: phase accumulator, half-rate toggle output
// and lock counter.
//   clkin, reset : clock and synchronous active-high reset
//   load, cfg    : load a new ratio/phase and restart the channel
//   sync         : reload the accumulator from the stored phase
//   ce           : registered one-cycle enable strobe
//   clk_q        : toggles with every strobe
//   locked       : set after LOCK_EDGES strobes since the last reset/load
module frac_ce_channel
  import frac_clk_pkg::*;
#(
  parameter int ACC_W      = 16,
  parameter int DEF_MUL    = 1,
  parameter int DEF_DIV    = 2,
  parameter int DEF_PHASE  = 0,
  parameter int LOCK_EDGES = 4
) (
  input  logic clkin,
  input  logic reset,
  input  logic load,
  input  cfg_t cfg,
  input  logic sync,
  output logic ce,
  output logic clk_q,
  output logic locked
);

  chan_state_t          st;
  logic [ACC_MAX_W:0]   sum;
  logic                 hit;
  logic [ACC_MAX_W-1:0] acc_nxt;

  // The result always fits in ACC_W bits (acc < div and mul <= div), so the
  // truncation keeps the upper accumulator bits tied to zero.
  always_comb begin
    sum     = {1'b0, st.acc} + {1'b0, st.mul};
    hit     = (sum >= {1'b0, st.div});
    acc_nxt = hit ? ACC_MAX_W'(ACC_W'(sum - {1'b0, st.div}))
                  : ACC_MAX_W'(ACC_W'(sum));
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      st.acc      <= ACC_MAX_W'(DEF_PHASE);
      st.mul      <= ACC_MAX_W'(DEF_MUL);
      st.div      <= ACC_MAX_W'(DEF_DIV);
      st.phase    <= ACC_MAX_W'(DEF_PHASE);
      st.ce       <= 1'b0;
      st.clk_q    <= 1'b0;
      st.lock_cnt <= '0;
      st.locked   <= 1'b0;
    end else if (load) begin
      st.acc      <= cfg.phase;
      st.mul      <= cfg.mul;
      st.div      <= cfg.div;
      st.phase    <= cfg.phase;
      st.ce       <= 1'b0;
      st.clk_q    <= 1'b0;
      st.lock_cnt <= '0;
      st.locked   <= 1'b0;
    end else begin
      if (sync) begin
        st.acc   <= st.phase;
        st.ce    <= 1'b0;
        st.clk_q <= 1'b0;
      end else begin
        st.acc <= acc_nxt;
        st.ce  <= hit;
        if (hit) st.clk_q <= ~st.clk_q;
      end
      // Count strobes already visible on ce; sync does not disturb lock state.
      if (st.ce && (st.lock_cnt < LOCK_CNT_W'(LOCK_EDGES))) begin
        st.lock_cnt <= st.lock_cnt + LOCK_CNT_W'(1);
        if (st.lock_cnt == LOCK_CNT_W'(LOCK_EDGES - 1)) st.locked <= 1'b1;
      end
    end
  end

  assign ce     = st.ce;
  assign clk_q  = st.clk_q;
  assign locked = st.locked;

endmodule

// File: rtl/frac_clk_en_gen.sv
// Runtime-reconfigurable fractional clock-enable generator.
// Each channel strobes ce at clkin * MUL/DIV with a programmable start phase.
//   clkin, reset          : sole clock, synchronous active-high reset
//   cfg_valid/cfg_ready   : config handshake; ready drops for the apply cycle
//   cfg_ch/mul/div/phase  : target channel and new ratio/preload
//   cfg_err               : one-cycle pulse for a rejected request
//   sync_all              : reload every channel from its stored phase
//   ce, clk_q, locked     : per-channel strobe, half-rate toggle, lock flag
//   lock_all              : registered AND of locked
// ACC_W must not exceed frac_clk_pkg::ACC_MAX_W.
module frac_clk_en_gen
  import frac_clk_pkg::*;
#(
  parameter  int CHANNELS   = 2,
  parameter  int ACC_W      = 16,
  parameter  int DEF_MUL    = 1,
  parameter  int DEF_DIV    = 2,
  parameter  int DEF_PHASE  = 0,
  parameter  int LOCK_EDGES = 4,
  localparam int CH_W       = ch_w(CHANNELS)
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_mul,
  input  logic [ACC_W-1:0]    cfg_div,
  input  logic [ACC_W-1:0]    cfg_phase,
  output logic                cfg_err,
  input  logic                sync_all,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] clk_q,
  output logic [CHANNELS-1:0] locked,
  output logic                lock_all
);

  cfg_t                cfg_in;
  logic                accept;
  logic                ch_ok;
  logic                good;
  logic [CHANNELS-1:0] load_vec;
  logic                apply_vld_p1;

  always_comb begin
    cfg_in.mul   = ACC_MAX_W'(cfg_mul);
    cfg_in.div   = ACC_MAX_W'(cfg_div);
    cfg_in.phase = ACC_MAX_W'(cfg_phase);
    accept       = cfg_valid && cfg_ready;
    ch_ok        = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
    good         = ch_ok && cfg_ok(cfg_in);
    for (int i = 0; i < CHANNELS; i++) begin
      load_vec[i] = accept && good && (cfg_ch == CH_W'(i));
    end
  end

  // Stage p1: the accepted request is being applied; the channel itself loads
  // on the accept edge, so this only shapes the handshake and error pulse.
  always_ff @(posedge clkin) begin
    if (reset) begin
      apply_vld_p1 <= 1'b0;
      cfg_err      <= 1'b0;
      lock_all     <= 1'b0;
    end else begin
      apply_vld_p1 <= accept && good;
      cfg_err      <= accept && !good;
      lock_all     <= &locked;
    end
  end

  assign cfg_ready = ~apply_vld_p1;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    frac_ce_channel #(
      .ACC_W      (ACC_W),
      .DEF_MUL    (DEF_MUL),
      .DEF_DIV    (DEF_DIV),
      .DEF_PHASE  (DEF_PHASE),
      .LOCK_EDGES (LOCK_EDGES)
    ) u_ch (
      .clkin  (clkin),
      .reset  (reset),
      .load   (load_vec[g]),
      .cfg    (cfg_in),
      .sync   (sync_all),
      .ce     (ce[g]),
      .clk_q  (clk_q[g]),
      .locked (locked[g])
    );
  end

endmodule

// File: tb/tb_frac_clk_en_gen.sv
// Testbench for frac_clk_en_gen. Three channels are instantiated so that
// cfg_ch is two bits wide and an out-of-range index (3) can be presented.
module tb_frac_clk_en_gen;

  localparam int NCH = 3;
  localparam int AW  = 16;

  logic           clkin = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [1:0]     cfg_ch = '0;
  logic [AW-1:0]  cfg_mul = '0;
  logic [AW-1:0]  cfg_div = '0;
  logic [AW-1:0]  cfg_phase = '0;
  logic           cfg_err;
  logic           sync_all = 1'b0;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] clk_q;
  logic [NCH-1:0] locked;
  logic           lock_all;

  int tests = 0;
  int fails = 0;

  frac_clk_en_gen #(
    .CHANNELS(NCH), .ACC_W(AW), .DEF_MUL(1), .DEF_DIV(2), .DEF_PHASE(0), .LOCK_EDGES(4)
  ) dut (
    .clkin(clkin), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mul(cfg_mul), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .sync_all(sync_all), .ce(ce), .clk_q(clk_q),
    .locked(locked), .lock_all(lock_all)
  );

  always #5 clkin = ~clkin;

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [2:0] ce;
    logic [2:0] clk_q;
    logic [2:0] locked;
    logic       lock_all;
    logic       cfg_ready;
    logic       cfg_err;
  } out_t;

  out_t exp_q[$];

  int m_acc[NCH], m_mul[NCH], m_div[NCH], m_ph[NCH], m_lc[NCH];
  bit m_ce[NCH], m_cq[NCH], m_lk[NCH];
  bit m_la, m_busy, m_err;

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit acc_ok, good, la_n;
    int sum;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_acc[i] = 0; m_mul[i] = 1; m_div[i] = 2; m_ph[i] = 0; m_lc[i] = 0;
        m_ce[i] = 0; m_cq[i] = 0; m_lk[i] = 0;
      end
      m_la = 0; m_busy = 0; m_err = 0;
      return;
    end
    acc_ok = cfg_valid && !m_busy;
    good = (int'(cfg_ch) < NCH) && (cfg_div != 0) && (cfg_mul != 0) &&
           (cfg_mul <= cfg_div) && (cfg_phase < cfg_div);
    la_n = m_lk[0] && m_lk[1] && m_lk[2];
    for (int i = 0; i < NCH; i++) begin
      if (acc_ok && good && (int'(cfg_ch) == i)) begin
        m_mul[i] = int'(cfg_mul); m_div[i] = int'(cfg_div); m_ph[i] = int'(cfg_phase);
        m_acc[i] = int'(cfg_phase); m_ce[i] = 0; m_cq[i] = 0; m_lc[i] = 0; m_lk[i] = 0;
      end else begin
        if (m_ce[i] && m_lc[i] < 4) begin
          m_lc[i]++;
          if (m_lc[i] == 4) m_lk[i] = 1;
        end
        if (sync_all) begin
          m_acc[i] = m_ph[i]; m_ce[i] = 0; m_cq[i] = 0;
        end else begin
          sum = m_acc[i] + m_mul[i];
          if (sum >= m_div[i]) begin
            m_acc[i] = sum - m_div[i]; m_ce[i] = 1; m_cq[i] = ~m_cq[i];
          end else begin
            m_acc[i] = sum; m_ce[i] = 0;
          end
        end
      end
    end
    m_la = la_n; m_busy = acc_ok && good; m_err = acc_ok && !good;
  endtask

  function automatic out_t model_out();
    out_t o;
    o.ce        = {m_ce[2], m_ce[1], m_ce[0]};
    o.clk_q     = {m_cq[2], m_cq[1], m_cq[0]};
    o.locked    = {m_lk[2], m_lk[1], m_lk[0]};
    o.lock_all  = m_la;
    o.cfg_ready = !m_busy;
    o.cfg_err   = m_err;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: predict, push, clock, then pop and compare the whole output set.
  int cyc = 0;
  task automatic step();
    out_t e, a;
    model_step();
    exp_q.push_back(model_out());
    @(posedge clkin);
    #1;
    cyc++;
    e = exp_q.pop_front();
    a = {ce, clk_q, locked, lock_all, cfg_ready, cfg_err};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL sb cyc %0d: got ce=%b clk_q=%b locked=%b la=%b rdy=%b err=%b expected ce=%b clk_q=%b locked=%b la=%b rdy=%b err=%b",
               cyc, a.ce, a.clk_q, a.locked, a.lock_all, a.cfg_ready, a.cfg_err,
               e.ce, e.clk_q, e.locked, e.lock_all, e.cfg_ready, e.cfg_err);
    end
  endtask

  task automatic set_cfg(input logic [1:0] ch, input int mul, input int div, input int ph);
    cfg_ch = ch; cfg_mul = AW'(mul); cfg_div = AW'(div); cfg_phase = AW'(ph);
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct packed {
    logic       rst;
    logic [2:0] ce;
    logic [2:0] clk_q;
    logic [2:0] locked;
    logic       lock_all;
    logic       cfg_ready;
  } dflt_vec_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] mul;
    logic [15:0] div;
    logic [15:0] phase;
  } rej_vec_t;

  dflt_vec_t dtab[13];
  rej_vec_t  rtab[5];
  logic [9:0] seq10;
  logic [6:0] seq7;
  logic [7:0] seq8;

  initial begin
    // Reset, then the default ratio 1/2 on every channel.
    dtab[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};
    dtab[1]  = '{1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};
    dtab[2]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};
    dtab[3]  = '{1'b0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1};
    dtab[4]  = '{1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1};
    dtab[5]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1};
    dtab[6]  = '{1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};
    dtab[7]  = '{1'b0, 3'b111, 3'b111, 3'b000, 1'b0, 1'b1};
    dtab[8]  = '{1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 1'b1};
    dtab[9]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1};
    dtab[10] = '{1'b0, 3'b000, 3'b000, 3'b111, 1'b0, 1'b1};
    dtab[11] = '{1'b0, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1};
    dtab[12] = '{1'b0, 3'b000, 3'b111, 3'b111, 1'b1, 1'b1};

    // Requests that must all be rejected.
    rtab[0] = '{2'd0, 16'd6, 16'd5, 16'd0};  // mul > div
    rtab[1] = '{2'd1, 16'd1, 16'd5, 16'd5};  // phase == div
    rtab[2] = '{2'd3, 16'd1, 16'd2, 16'd0};  // channel out of range
    rtab[3] = '{2'd0, 16'd0, 16'd5, 16'd0};  // mul == 0
    rtab[4] = '{2'd0, 16'd1, 16'd0, 16'd0};  // div == 0

    for (int k = 0; k < 13; k++) begin
      reset = dtab[k].rst;
      step();
      check($sformatf("dflt[%0d]", k), 32'({ce, clk_q, locked, lock_all, cfg_ready}),
            32'({dtab[k].ce, dtab[k].clk_q, dtab[k].locked, dtab[k].lock_all, dtab[k].cfg_ready}));
    end
    check("rst_err_low", 32'(cfg_err), 32'd0);

    for (int r = 0; r < 5; r++) begin
      set_cfg(rtab[r].ch, int'(rtab[r].mul), int'(rtab[r].div), int'(rtab[r].phase));
      cfg_valid = 1'b1;
      step();
      check($sformatf("rej[%0d]_err", r), 32'({cfg_err, cfg_ready}), 32'b11);
      cfg_valid = 1'b0;
      step();
      check($sformatf("rej[%0d]_after", r), 32'({cfg_err, locked}), 32'b0111);
    end

    // ch0 -> 2/5, phase 0.
    set_cfg(2'd0, 2, 5, 0);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("c0_apply", 32'({cfg_ready, ce[0], clk_q[0], locked[0]}), 32'b0000);
    seq10 = '0;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k <= 10) seq10 = {seq10[8:0], ce[0]};
      if (k == 1)  check("c0_ready_back", 32'(cfg_ready), 32'd1);
      if (k == 10) check("c0_not_locked", 32'(locked[0]), 32'd0);
      if (k == 11) check("c0_locked", 32'(locked[0]), 32'd1);
    end
    check("c0_ce_seq", 32'(seq10), 32'(10'b0010100101));
    check("c0_ch1_undisturbed", 32'(locked[1]), 32'd1);

    // ch1 -> 1/3, phase 2: first strobe right after the apply cycle.
    set_cfg(2'd1, 1, 3, 2);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    check("c1_apply", 32'({cfg_ready, ce[1]}), 32'b00);
    seq7 = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      seq7 = {seq7[5:0], ce[1]};
    end
    check("c1_ce_seq", 32'(seq7), 32'(7'b1001001));

    // ch0 and ch1 -> 1/4; the second request is held through the busy cycle.
    set_cfg(2'd0, 1, 4, 0);
    cfg_valid = 1'b1;
    step();
    set_cfg(2'd1, 1, 4, 0);
    step();
    check("hold_busy_ready", 32'({cfg_ready, cfg_err}), 32'b10);
    step();
    check("hold_accepted", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    repeat (24) step();
    check("pre_sync_locked", 32'(locked), 32'b111);

    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    check("sync_state", 32'({ce, clk_q, locked}), 32'({3'b000, 3'b000, 3'b111}));
    seq8 = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      seq8 = {seq8[5:0], ce[1:0]};
    end
    check("sync_ce_seq", 32'(seq8), 32'(8'b00_00_00_11));

    // Config on ch0 together with sync_all.
    set_cfg(2'd0, 1, 2, 1);
    cfg_valid = 1'b1;
    sync_all = 1'b1;
    step();
    cfg_valid = 1'b0;
    sync_all = 1'b0;
    check("cfg_sync_apply", 32'({cfg_ready, ce, clk_q, locked}), 32'({1'b0, 3'b000, 3'b000, 3'b110}));
    step();
    check("cfg_sync_next", 32'(ce), 32'b001);
    repeat (3) step();

    // Reset mid-stream with a pending valid request and sync.
    reset = 1'b1;
    set_cfg(2'd1, 1, 3, 0);
    cfg_valid = 1'b1;
    sync_all = 1'b1;
    step();
    check("midrst_state", 32'({ce, clk_q, locked, lock_all, cfg_ready, cfg_err}),
          32'({3'b000, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0}));
    reset = 1'b0;
    cfg_valid = 1'b0;
    sync_all = 1'b0;
    step();
    step();
    check("midrst_defaults", 32'(ce), 32'b111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
